sram_1rw1r_param: RTL and testbench
===================================

Name: sram_1rw1r_param

Overview:
- Parametrised, single-clock successor to the fixed 32x256 1RW1R SRAM model; synthesisable behavioural RAM for the BRAM tile.
- Port 0 reads or writes with byte masks; port 1 is read-only.
- Adds the following:
  - post-reset clear sequencer;
  - explicit read-valid strobes;
  - optional output register;
  - a defined read-during-write collision policy;
  - out-of-range address handling.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 8, address width.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words. Must be <= 2^ADDR_WIDTH.
- NUM_WMASKS, 4, write-mask lanes. DATA_WIDTH % NUM_WMASKS must be 0; lane width = DATA_WIDTH/NUM_WMASKS.
- OUT_REG, 0, 0 gives 1-cycle read latency; 1 gives 2-cycle latency.
- BYPASS, 1, 1 makes a port-1 read colliding with a port-0 write return the new data; 0 returns the old data.
- CLEAR_ON_RESET, 1, 1 zero-fills the array after reset.

Ports:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, reset; synchronous, active-low.
- init_busy, out, 1, high while the clear sequencer runs.
- csb0, in, 1, port 0 active-low select.
- web0, in, 1, port 0 active-low write enable.
- wmask0, in, NUM_WMASKS, port 0 lane write enables.
- addr0, in, ADDR_WIDTH, port 0 address.
- din0, in, DATA_WIDTH, port 0 write data.
- dout0, out, DATA_WIDTH, port 0 read data.
- dout0_valid, out, 1, dout0 carries a new read result this cycle.
- csb1, in, 1, port 1 active-low select.
- addr1, in, ADDR_WIDTH, port 1 address.
- dout1, out, DATA_WIDTH, port 1 read data.
- dout1_valid, out, 1, dout1 carries a new read result this cycle.
- collision, out, 1, pulses together with the dout1_valid of a colliding read.

Behaviour:
- One clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - dout0 = dout1 = 0;
  - dout0_valid = dout1_valid = collision = 0;
  - all pipeline valids cleared;
  - init_busy = CLEAR_ON_RESET.
- FSM, states ST_CLEAR and ST_READY:
  - Reset enters ST_CLEAR if CLEAR_ON_RESET, otherwise ST_READY.
  - ST_CLEAR writes 0 to address clr_cnt and increments clr_cnt each cycle, starting at 0.
  - At clr_cnt = RAM_DEPTH-1 it goes to ST_READY. Clear takes exactly RAM_DEPTH cycles after rst_n rises.
  - init_busy = (state == ST_CLEAR).
- While init_busy:
  - all port requests are ignored: no write, no valid;
  - dout0/dout1 hold 0.
- Reset asserted mid-operation (mid-clear or with reads in flight):
  - in-flight reads are dropped;
  - valids go to 0;
  - clear restarts at address 0.
  - Array contents are not otherwise touched.
- Port 0 write (csb0=0, web0=0), committed at the sampling edge:
  - for each lane i with wmask0[i]=1, mem[addr0] lane i <= din0 lane i;
  - unmasked lanes keep their value;
  - wmask0 = 0 is a legal no-op;
  - dout0 holds, dout0_valid = 0.
- Port 0 read (csb0=0, web0=1) and port 1 read (csb1=0):
  - data appears 1 + OUT_REG cycles after the sampling edge, with a matching single-cycle valid;
  - back-to-back reads are fully pipelined, one result per cycle.
  - With no read, dout holds its last value (never X) and valid = 0.
- Collision: port-0 write and port-1 read to the same in-range address on the same edge.
  - BYPASS=1: dout1 = merged word (masked lanes from din0, others from the old word).
  - BYPASS=0: dout1 = old word.
  - collision = 1 aligned with that dout1_valid.
  - Port-0 and port-1 reads of the same address are not a collision.
- Out-of-range address (addr >= RAM_DEPTH):
  - writes are dropped;
  - reads return all-zero with valid = 1;
  - no collision is flagged.
- Address is not wrapped modulo RAM_DEPTH.

Decomposition:
- Package sram_pkg holds:
  - state enum (ST_CLEAR, ST_READY);
  - function lane_merge(old, new, mask, lanes) used by both write and bypass;
  - elaboration checks for the DATA_WIDTH/NUM_WMASKS and RAM_DEPTH constraints.
- One sub-module, sram_rd_stage, instantiated once per read port: valid/data pipeline, hold-on-idle, OUT_REG generate, reset clear.

Test Plan:
- Reset, defaults: rst_n low 2 cycles then high -> init_busy high exactly 256 cycles then low; a port-1 read of addr 8'h7F afterwards returns 0 with dout1_valid one cycle later.
- Masked write: mem[8'h10] preset 32'hAABBCCDD; write din0 = 32'h11223344, wmask0 = 4'b0101; then port-0 read of 8'h10 -> 32'hAA22CC44, dout0_valid one cycle after the read edge; dout0 unchanged on the write cycle.
- Collision, BYPASS=1: mem[8'h20] = 32'h0; same edge port-0 write 32'hFFFFFFFF with mask 4'b0011 and port-1 read of 8'h20 -> dout1 = 32'h0000FFFF, collision = 1. Rerun with BYPASS=0 -> dout1 = 0, collision = 1.
- OUT_REG=1: port-1 reads of 1, 2, 3 on consecutive cycles -> three results on consecutive cycles, first valid two cycles after the first edge; dout1 holds the third result afterwards.
- Out-of-range, RAM_DEPTH=200: write to 8'hC8, then read 8'hC8 -> 0 with valid = 1; mem[8'h48] unchanged.
- Reset mid-clear: drop rst_n at clear cycle 100 for 1 cycle -> init_busy stays high for a further 256 cycles after rst_n rises; reads issued during busy produce no valid.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1RW1R SRAM: FSM states,
// byte-lane merge used by both the write path and the port-1 bypass.
package sram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  localparam int unsigned MAX_DW    = 1024;
  localparam int unsigned MAX_LANES = 128;

  // Bits of lanes whose mask bit is set come from new_word, all others from old_word.
  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0]    old_word,
    input logic [MAX_DW-1:0]    new_word,
    input logic [MAX_LANES-1:0] mask,
    input int unsigned          lanes,
    input int unsigned          lane_w
  );
    logic [MAX_DW-1:0] res;
    res = old_word;
    for (int unsigned b = 0; b < MAX_DW; b++) begin
      if ((lane_w != 0) && (b < lanes * lane_w) && mask[7'(b / lane_w)]) begin
        res[b[9:0]] = new_word[b[9:0]];
      end
    end
    return res;
  endfunction

  function automatic bit cfg_ok(
    input int unsigned dw,
    input int unsigned aw,
    input int unsigned depth,
    input int unsigned lanes
  );
    return (lanes != 0) && (lanes <= MAX_LANES) && (dw <= MAX_DW) &&
           ((dw % lanes) == 0) && (depth >= 1) && (aw < 32) &&
           (64'(depth) <= (64'd1 << aw));
  endfunction

endpackage

// File: rtl/sram_1rw1r_param_rd_stage.sv
// Read-result pipeline for one SRAM read port: 1 or 2 stages, data holds when idle.
module sram_rd_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OUT_REG = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;

  always_comb begin
    s1_valid_d = rd_en;
    s1_data_d  = rd_en ? rd_data : s1_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;

    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign dout       = s2_data_q;
    assign dout_valid = s2_valid_q;
  end else begin : g_no_out_reg
    assign dout       = s1_data_q;
    assign dout_valid = s1_valid_q;
  end

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised single-clock 1RW1R behavioural SRAM with post-reset clear,
// read-valid strobes, optional output register and port-1 collision bypass.
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int unsigned NUM_WMASKS     = 4,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned BYPASS         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision
);

  if (!cfg_ok(DATA_WIDTH, ADDR_WIDTH, RAM_DEPTH, NUM_WMASKS)) begin : g_cfg_err
    $error("sram_1rw1r_param: invalid DATA_WIDTH/NUM_WMASKS/RAM_DEPTH/ADDR_WIDTH");
  end

  localparam int unsigned           LANE_W    = DATA_WIDTH / NUM_WMASKS;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  init_busy_q, init_busy_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_ADDR) begin
        state_d   = ST_READY;
        clr_cnt_d = '0;
      end
    end
    init_busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q   <= '0;
      init_busy_q <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_busy_q <= init_busy_d;
    end
  end

  assign init_busy = init_busy_q;

  logic                  ready;
  logic                  in_rng0, in_rng1;
  logic                  wr0, rd0, rd1, coll1;
  logic [DATA_WIDTH-1:0] old0, old1, merged0, rd1_data;

  assign ready   = rst_n && (state_q == ST_READY);
  assign in_rng0 = ({1'b0, addr0} < DEPTH_EXT);
  assign in_rng1 = ({1'b0, addr1} < DEPTH_EXT);
  assign wr0     = ready && !csb0 && !web0;
  assign rd0     = ready && !csb0 && web0;
  assign rd1     = ready && !csb1;
  assign old0    = in_rng0 ? mem_q[addr0] : '0;
  assign old1    = in_rng1 ? mem_q[addr1] : '0;
  assign merged0 = DATA_WIDTH'(lane_merge(MAX_DW'(old0), MAX_DW'(din0),
                                          MAX_LANES'(wmask0), NUM_WMASKS, LANE_W));

  // in_rng0 with equal addresses implies in_rng1, so out-of-range never collides.
  assign coll1    = wr0 && rd1 && in_rng0 && (addr0 == addr1);
  assign rd1_data = (coll1 && (BYPASS != 0)) ? merged0 : old1;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr0;
    mem_wdata = merged0;
    if (rst_n && (state_q == ST_CLEAR)) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else if (wr0 && in_rng0) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  sram_rd_stage #(
    .WIDTH  (DATA_WIDTH),
    .OUT_REG(OUT_REG)
  ) u_rd0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd0),
    .rd_data   (old0),
    .dout      (dout0),
    .dout_valid(dout0_valid)
  );

  // Port 1 carries the collision tag as an extra data bit through its pipeline.
  logic rd1_tag;

  sram_rd_stage #(
    .WIDTH  (DATA_WIDTH + 1),
    .OUT_REG(OUT_REG)
  ) u_rd1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd1),
    .rd_data   ({coll1, rd1_data}),
    .dout      ({rd1_tag, dout1}),
    .dout_valid(dout1_valid)
  );

  assign collision = dout1_valid && rd1_tag;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Scoreboard bench for sram_1rw1r_param: instance A uses defaults, instance B
// uses RAM_DEPTH=200, OUT_REG=1, BYPASS=0.
module tb_sram_1rw1r_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  typedef struct {
    logic [31:0] data;
    logic        coll;
    int unsigned due;
  } exp_t;

  exp_t sbq [4][$];

  logic [31:0] model_a [256];
  logic [31:0] model_b [256];

  logic        a_rst_n, a_init_busy, a_csb0, a_web0, a_csb1;
  logic [3:0]  a_wmask0;
  logic [7:0]  a_addr0, a_addr1;
  logic [31:0] a_din0, a_dout0, a_dout1;
  logic        a_dout0_valid, a_dout1_valid, a_collision;

  logic        b_rst_n, b_init_busy, b_csb0, b_web0, b_csb1;
  logic [3:0]  b_wmask0;
  logic [7:0]  b_addr0, b_addr1;
  logic [31:0] b_din0, b_dout0, b_dout1;
  logic        b_dout0_valid, b_dout1_valid, b_collision;

  sram_1rw1r_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(256), .NUM_WMASKS(4),
    .OUT_REG(0), .BYPASS(1), .CLEAR_ON_RESET(1)
  ) u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .init_busy(a_init_busy),
    .csb0(a_csb0), .web0(a_web0), .wmask0(a_wmask0), .addr0(a_addr0), .din0(a_din0),
    .dout0(a_dout0), .dout0_valid(a_dout0_valid),
    .csb1(a_csb1), .addr1(a_addr1), .dout1(a_dout1), .dout1_valid(a_dout1_valid),
    .collision(a_collision)
  );

  sram_1rw1r_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(200), .NUM_WMASKS(4),
    .OUT_REG(1), .BYPASS(0), .CLEAR_ON_RESET(1)
  ) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .init_busy(b_init_busy),
    .csb0(b_csb0), .web0(b_web0), .wmask0(b_wmask0), .addr0(b_addr0), .din0(b_din0),
    .dout0(b_dout0), .dout0_valid(b_dout0_valid),
    .csb1(b_csb1), .addr1(b_addr1), .dout1(b_dout1), .dout1_valid(b_dout1_valid),
    .collision(b_collision)
  );

  logic [31:0] mon_d [4];
  logic        mon_v [4];
  logic        mon_c [4];
  assign mon_d[0] = a_dout0;  assign mon_v[0] = a_dout0_valid;  assign mon_c[0] = 1'b0;
  assign mon_d[1] = a_dout1;  assign mon_v[1] = a_dout1_valid;  assign mon_c[1] = a_collision;
  assign mon_d[2] = b_dout0;  assign mon_v[2] = b_dout0_valid;  assign mon_c[2] = 1'b0;
  assign mon_d[3] = b_dout1;  assign mon_v[3] = b_dout1_valid;  assign mon_c[3] = b_collision;

  always @(negedge clk) begin
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      if (mon_v[p] === 1'b1) begin
        chk_cnt++;
        if (sbq[p].size() == 0) begin
          $display("FAIL sb_unexpected_valid port%0d cyc=%0d: got valid with data=%h, required no valid",
                   p, cyc, mon_d[p]);
        end else begin
          e = sbq[p].pop_front();
          if (mon_d[p] !== e.data || mon_c[p] !== e.coll || cyc != e.due)
            $display("FAIL sb_read port%0d: got data=%h coll=%b cyc=%0d, required data=%h coll=%b cyc=%0d",
                     p, mon_d[p], mon_c[p], cyc, e.data, e.coll, e.due);
          else
            pass_cnt++;
        end
      end else if (mon_c[p] === 1'b1) begin
        chk_cnt++;
        $display("FAIL spurious_collision port%0d cyc=%0d: got collision=1 without valid, required 0", p, cyc);
      end
    end
  end

  task automatic set_idle();
    a_csb0 = 1'b1; a_web0 = 1'b1; a_wmask0 = '0; a_addr0 = '0; a_din0 = '0;
    a_csb1 = 1'b1; a_addr1 = '0;
    b_csb0 = 1'b1; b_web0 = 1'b1; b_wmask0 = '0; b_addr0 = '0; b_din0 = '0;
    b_csb1 = 1'b1; b_addr1 = '0;
  endtask

  task automatic step();
    @(negedge clk);
    set_idle();
  endtask

  task automatic issue_write(input bit sel_b, input logic [7:0] addr,
                             input logic [31:0] data, input logic [3:0] mask);
    if (!sel_b) begin
      a_csb0 = 1'b0; a_web0 = 1'b0; a_addr0 = addr; a_din0 = data; a_wmask0 = mask;
      for (int i = 0; i < 4; i++)
        if (mask[i]) model_a[addr][8*i +: 8] = data[8*i +: 8];
    end else begin
      b_csb0 = 1'b0; b_web0 = 1'b0; b_addr0 = addr; b_din0 = data; b_wmask0 = mask;
      if (addr < 8'd200)
        for (int i = 0; i < 4; i++)
          if (mask[i]) model_b[addr][8*i +: 8] = data[8*i +: 8];
    end
  endtask

  task automatic issue_read(input bit sel_b, input bit port, input logic [7:0] addr,
                            input logic coll);
    exp_t e;
    e.coll = coll;
    if (!sel_b) begin
      e.data = model_a[addr];
      e.due  = cyc + 1;
      if (!port) begin a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = addr; end
      else       begin a_csb1 = 1'b0; a_addr1 = addr; end
    end else begin
      e.data = (addr < 8'd200) ? model_b[addr] : 32'h0;
      e.due  = cyc + 2;
      if (!port) begin b_csb0 = 1'b0; b_web0 = 1'b1; b_addr0 = addr; end
      else       begin b_csb1 = 1'b0; b_addr1 = addr; end
    end
    sbq[{30'd0, sel_b, port}].push_back(e);
  endtask

  task automatic test_reset();
    int unsigned na, nb;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    set_idle();
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (a_init_busy !== 1'b1 || b_init_busy !== 1'b1)
      $display("FAIL reset_busy: got a=%b b=%b, required 1 1", a_init_busy, b_init_busy);
    else pass_cnt++;
    chk_cnt++;
    if (a_dout0 !== 32'h0 || a_dout1 !== 32'h0 || b_dout0 !== 32'h0 || b_dout1 !== 32'h0)
      $display("FAIL reset_dout: got %h %h %h %h, required all 0", a_dout0, a_dout1, b_dout0, b_dout1);
    else pass_cnt++;
    chk_cnt++;
    if ({a_dout0_valid, a_dout1_valid, a_collision, b_dout0_valid, b_dout1_valid, b_collision} !== 6'b0)
      $display("FAIL reset_valids: got %b%b%b%b%b%b, required 000000", a_dout0_valid, a_dout1_valid,
               a_collision, b_dout0_valid, b_dout1_valid, b_collision);
    else pass_cnt++;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    na = 0; nb = 0;
    for (int k = 0; k < 1000; k++) begin
      if (a_init_busy === 1'b1) na++;
      if (b_init_busy === 1'b1) nb++;
      if (a_init_busy !== 1'b1 && b_init_busy !== 1'b1) break;
      @(negedge clk);
    end
    chk_cnt++;
    if (na != 256) $display("FAIL clear_len_a: got %0d busy cycles, required 256", na);
    else pass_cnt++;
    chk_cnt++;
    if (nb != 200) $display("FAIL clear_len_b: got %0d busy cycles, required 200", nb);
    else pass_cnt++;
    for (int i = 0; i < 256; i++) begin model_a[i] = '0; model_b[i] = '0; end
    issue_read(1'b0, 1'b1, 8'h7F, 1'b0);
    issue_read(1'b1, 1'b1, 8'h7F, 1'b0);
    step();
    chk_cnt++;
    if (a_dout1_valid !== 1'b1 || a_dout1 !== 32'h0)
      $display("FAIL first_read_a: got valid=%b data=%h, required valid=1 data=0", a_dout1_valid, a_dout1);
    else pass_cnt++;
    step(); step();
  endtask

  task automatic test_masked_write();
    logic [31:0] d0;
    issue_write(1'b0, 8'h10, 32'hAABBCCDD, 4'hF);
    step();
    d0 = a_dout0;
    issue_write(1'b0, 8'h10, 32'h11223344, 4'b0101);
    step();
    chk_cnt++;
    if (a_dout0 !== d0 || a_dout0_valid !== 1'b0)
      $display("FAIL write_cycle_dout0: got data=%h valid=%b, required data=%h valid=0", a_dout0, a_dout0_valid, d0);
    else pass_cnt++;
    issue_write(1'b0, 8'h10, 32'hFFFFFFFF, 4'b0000);
    step();
    issue_read(1'b0, 1'b0, 8'h10, 1'b0);
    step();
    chk_cnt++;
    if (a_dout0 !== 32'hAA22CC44 || a_dout0_valid !== 1'b1)
      $display("FAIL masked_write: got data=%h valid=%b, required data=aa22cc44 valid=1", a_dout0, a_dout0_valid);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (a_dout0 !== 32'hAA22CC44 || a_dout0_valid !== 1'b0)
      $display("FAIL dout0_hold: got data=%h valid=%b, required data=aa22cc44 valid=0", a_dout0, a_dout0_valid);
    else pass_cnt++;
  endtask

  task automatic test_collision_bypass();
    issue_write(1'b0, 8'h20, 32'hFFFFFFFF, 4'b0011);
    issue_read(1'b0, 1'b1, 8'h20, 1'b1);
    step();
    chk_cnt++;
    if (a_dout1 !== 32'h0000FFFF || a_collision !== 1'b1)
      $display("FAIL coll_bypass: got data=%h coll=%b, required data=0000ffff coll=1", a_dout1, a_collision);
    else pass_cnt++;
    issue_read(1'b0, 1'b0, 8'h20, 1'b0);
    issue_read(1'b0, 1'b1, 8'h20, 1'b0);
    step();
    chk_cnt++;
    if (a_collision !== 1'b0)
      $display("FAIL read_read_no_coll: got coll=%b, required 0", a_collision);
    else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      issue_write(1'b0, 8'h30 + 8'(i), $urandom, 4'hF);
      if (i > 0) issue_read(1'b0, 1'b1, 8'h30 + 8'(i - 1), 1'b0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      issue_read(1'b0, 1'b0, 8'h30 + 8'(i), 1'b0);
      issue_read(1'b0, 1'b1, 8'h37 - 8'(i), 1'b0);
      step();
    end
    step();
  endtask

  task automatic test_out_reg();
    issue_write(1'b1, 8'd1, 32'h01010101, 4'hF); step();
    issue_write(1'b1, 8'd2, 32'h02020202, 4'hF); step();
    issue_write(1'b1, 8'd3, 32'h03030303, 4'hF); step();
    issue_read(1'b1, 1'b1, 8'd1, 1'b0); step();
    chk_cnt++;
    if (b_dout1_valid !== 1'b0)
      $display("FAIL out_reg_latency: got valid=%b one cycle after edge, required 0", b_dout1_valid);
    else pass_cnt++;
    issue_read(1'b1, 1'b1, 8'd2, 1'b0); step();
    issue_read(1'b1, 1'b1, 8'd3, 1'b0); step();
    repeat (3) step();
    chk_cnt++;
    if (b_dout1 !== 32'h03030303 || b_dout1_valid !== 1'b0)
      $display("FAIL out_reg_hold: got data=%h valid=%b, required data=03030303 valid=0", b_dout1, b_dout1_valid);
    else pass_cnt++;
  endtask

  task automatic test_collision_nobypass();
    issue_read(1'b1, 1'b1, 8'h20, 1'b1);
    issue_write(1'b1, 8'h20, 32'hFFFFFFFF, 4'b0011);
    step(); step();
    chk_cnt++;
    if (b_dout1 !== 32'h0 || b_collision !== 1'b1)
      $display("FAIL coll_nobypass: got data=%h coll=%b, required data=0 coll=1", b_dout1, b_collision);
    else pass_cnt++;
    issue_read(1'b1, 1'b0, 8'h20, 1'b0);
    step(); step(); step();
  endtask

  task automatic test_out_of_range();
    issue_write(1'b1, 8'h48, 32'h5A5A5A5A, 4'hF); step();
    issue_write(1'b1, 8'hC8, 32'hDEADBEEF, 4'hF); step();
    issue_read(1'b1, 1'b0, 8'hC8, 1'b0);
    issue_read(1'b1, 1'b1, 8'h48, 1'b0);
    step(); step();
    chk_cnt++;
    if (b_dout0 !== 32'h0 || b_dout0_valid !== 1'b1)
      $display("FAIL oor_read: got data=%h valid=%b, required data=0 valid=1", b_dout0, b_dout0_valid);
    else pass_cnt++;
    chk_cnt++;
    if (b_dout1 !== 32'h5A5A5A5A)
      $display("FAIL no_wrap: got mem[48]=%h, required 5a5a5a5a", b_dout1);
    else pass_cnt++;
    issue_write(1'b1, 8'hC8, 32'h12345678, 4'hF);
    issue_read(1'b1, 1'b1, 8'hC8, 1'b0);
    step();
    issue_write(1'b1, 8'hC7, 32'h13579BDF, 4'hF); step();
    issue_read(1'b1, 1'b1, 8'hC7, 1'b0);
    issue_read(1'b1, 1'b0, 8'hFF, 1'b0);
    step(); step(); step();
  endtask

  task automatic test_reset_mid_clear();
    int unsigned n;
    bit          bad;
    a_rst_n = 1'b0; @(negedge clk);
    a_rst_n = 1'b1;
    repeat (100) @(negedge clk);
    a_rst_n = 1'b0; @(negedge clk);
    a_rst_n = 1'b1;
    n = 0; bad = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (a_dout0_valid !== 1'b0 || a_dout1_valid !== 1'b0 || a_dout0 !== 32'h0 || a_dout1 !== 32'h0)
        bad = 1'b1;
      if (a_init_busy !== 1'b1) break;
      n++;
      a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 8'(k);
      a_csb1 = 1'b0; a_addr1 = 8'(k);
      @(negedge clk);
    end
    set_idle();
    chk_cnt++;
    if (n != 256) $display("FAIL mid_clear_len: got %0d busy cycles, required 256", n);
    else pass_cnt++;
    chk_cnt++;
    if (bad) $display("FAIL busy_ignored: got valid or nonzero dout while busy, required none");
    else pass_cnt++;
    for (int i = 0; i < 256; i++) model_a[i] = '0;
    issue_read(1'b0, 1'b1, 8'h10, 1'b0);
    issue_read(1'b0, 1'b0, 8'h30, 1'b0);
    step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_masked_write();
    test_collision_bypass();
    test_back_to_back();
    test_out_reg();
    test_collision_nobypass();
    test_out_of_range();
    test_reset_mid_clear();
    repeat (3) step();
    for (int p = 0; p < 4; p++) begin
      chk_cnt++;
      if (sbq[p].size() != 0)
        $display("FAIL sb_drain port%0d: got %0d outstanding reads, required 0", p, sbq[p].size());
      else pass_cnt++;
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
